// File: rtl/rx_cmd_ctrl.sv
// rx_cmd_ctrl: command decoder between a UART receiver/transmitter, a
// 16x8 register file and an ALU.
//   0xAA addr data   -> register-file write
//   0xBB addr        -> register-file read, read byte sent back over TX
//   0xCC a b fun     -> write operands to regs 0/1, run ALU, send result (LO, HI)
//   0xDD fun         -> run ALU on the current operands, send result (LO, HI)
// Ports:
//   CLK, RST (async, active-low)
//   RX_P_DATA/RX_D_VLD/RX_ERR         : receiver byte stream
//   RF_WrEn/RF_RdEn/RF_Address/RF_WrData, RF_RdData/RF_RdData_Valid : register file
//   ALU_EN/ALU_FUN, ALU_OUT/ALU_OUT_VLD, CLK_GATE_EN                : ALU
//   TX_P_DATA/TX_D_VLD, TX_BUSY        : transmitter handshake
// All outputs come straight from flops.
module rx_cmd_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_P_DATA,
  input  logic        RX_D_VLD,
  input  logic        RX_ERR,
  output logic        RF_WrEn,
  output logic        RF_RdEn,
  output logic [3:0]  RF_Address,
  output logic [7:0]  RF_WrData,
  input  logic [7:0]  RF_RdData,
  input  logic        RF_RdData_Valid,
  output logic        ALU_EN,
  output logic [3:0]  ALU_FUN,
  input  logic [15:0] ALU_OUT,
  input  logic        ALU_OUT_VLD,
  output logic        CLK_GATE_EN,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_D_VLD,
  input  logic        TX_BUSY
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYC);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    OP_A     = 4'd5,
    OP_B     = 4'd6,
    FUN      = 4'd7,
    ALU_WAIT = 4'd8,
    TX_LO    = 4'd9,
    TX_HI    = 4'd10,
    TX_RD    = 4'd11
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_wr_en, r_rd_en, r_alu_en, r_tx_vld, r_gate;
  logic        w_wr_en_nxt, w_rd_en_nxt, w_alu_en_nxt, w_tx_vld_nxt, w_gate_nxt;
  logic [3:0]  r_addr_out, w_addr_out_nxt;
  logic [7:0]  r_wr_data, w_wr_data_nxt;
  logic [3:0]  r_alu_fun, w_alu_fun_nxt;
  logic [7:0]  r_tx_data, w_tx_data_nxt;
  logic [3:0]  r_wr_addr, w_wr_addr_nxt;   // address held between WR_ADDR and WR_DATA
  logic [7:0]  r_rd_byte, w_rd_byte_nxt;   // captured register-file read data
  logic [15:0] r_alu_res, w_alu_res_nxt;   // captured ALU result
  // TX phase: 0 = wait to issue, 1 = strobe out, 2 = wait busy rise, 3 = wait busy fall
  logic [1:0]  r_tx_ph, w_tx_ph_nxt;
  logic [7:0]  r_tmo_cnt, w_tmo_nxt;
  logic        w_tmo_run, w_abort;
  logic [7:0]  w_tx_byte;

  assign RF_WrEn     = r_wr_en;
  assign RF_RdEn     = r_rd_en;
  assign RF_Address  = r_addr_out;
  assign RF_WrData   = r_wr_data;
  assign ALU_EN      = r_alu_en;
  assign ALU_FUN     = r_alu_fun;
  assign CLK_GATE_EN = r_gate;
  assign TX_P_DATA   = r_tx_data;
  assign TX_D_VLD    = r_tx_vld;

  // Byte-awaiting states run the inter-byte timeout and honour RX_ERR.
  always_comb begin
    case (r_state)
      WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUN: w_tmo_run = 1'b1;
      default:                                    w_tmo_run = 1'b0;
    endcase
    w_abort = w_tmo_run & (RX_ERR | (r_tmo_cnt == TMO_LIMIT));
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_en_nxt    = 1'b0;
    w_rd_en_nxt    = 1'b0;
    w_alu_en_nxt   = 1'b0;
    w_tx_vld_nxt   = 1'b0;
    w_gate_nxt     = 1'b0;
    w_addr_out_nxt = r_addr_out;
    w_wr_data_nxt  = r_wr_data;
    w_alu_fun_nxt  = r_alu_fun;
    w_tx_data_nxt  = r_tx_data;
    w_wr_addr_nxt  = r_wr_addr;
    w_rd_byte_nxt  = r_rd_byte;
    w_alu_res_nxt  = r_alu_res;
    w_tx_ph_nxt    = r_tx_ph;
    w_tx_byte      = 8'h00;

    case (r_state)
      IDLE: begin
        w_tx_ph_nxt = 2'd0;
        // A byte flagged with RX_ERR is never decoded.
        if (RX_D_VLD && !RX_ERR) begin
          case (RX_P_DATA)
            8'hAA:   w_state_nxt = WR_ADDR;
            8'hBB:   w_state_nxt = RD_ADDR;
            8'hCC:   w_state_nxt = OP_A;
            8'hDD:   w_state_nxt = FUN;
            default: w_state_nxt = IDLE;
          endcase
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUN: begin
        if (w_abort) begin
          w_state_nxt = IDLE;
        end else if (RX_D_VLD) begin
          case (r_state)
            WR_ADDR: begin
              w_wr_addr_nxt = RX_P_DATA[3:0];
              w_state_nxt   = WR_DATA;
            end
            WR_DATA: begin
              w_wr_en_nxt    = 1'b1;
              w_addr_out_nxt = r_wr_addr;
              w_wr_data_nxt  = RX_P_DATA;
              w_state_nxt    = IDLE;
            end
            RD_ADDR: begin
              w_rd_en_nxt    = 1'b1;
              w_addr_out_nxt = RX_P_DATA[3:0];
              w_state_nxt    = RD_WAIT;
            end
            OP_A: begin
              w_wr_en_nxt    = 1'b1;
              w_addr_out_nxt = 4'd0;
              w_wr_data_nxt  = RX_P_DATA;
              w_state_nxt    = OP_B;
            end
            OP_B: begin
              w_wr_en_nxt    = 1'b1;
              w_addr_out_nxt = 4'd1;
              w_wr_data_nxt  = RX_P_DATA;
              w_state_nxt    = FUN;
            end
            default: begin  // FUN
              w_alu_fun_nxt = RX_P_DATA[3:0];
              w_alu_en_nxt  = 1'b1;
              w_gate_nxt    = 1'b1;
              w_state_nxt   = ALU_WAIT;
            end
          endcase
        end else begin
          w_state_nxt = r_state;
        end
      end
      RD_WAIT: begin
        if (RF_RdData_Valid) begin
          w_rd_byte_nxt = RF_RdData;
          w_tx_ph_nxt   = 2'd0;
          w_state_nxt   = TX_RD;
        end else begin
          w_state_nxt = RD_WAIT;
        end
      end
      ALU_WAIT: begin
        // Gate stays on through the cycle after ALU_OUT_VLD; TX_LO drops it.
        w_gate_nxt = 1'b1;
        if (ALU_OUT_VLD) begin
          w_alu_res_nxt = ALU_OUT;
          w_tx_ph_nxt   = 2'd0;
          w_state_nxt   = TX_LO;
        end else begin
          w_state_nxt = ALU_WAIT;
        end
      end
      TX_LO, TX_HI, TX_RD: begin
        if (r_state == TX_LO) begin
          w_tx_byte = r_alu_res[7:0];
        end else if (r_state == TX_HI) begin
          w_tx_byte = r_alu_res[15:8];
        end else begin
          w_tx_byte = r_rd_byte;
        end
        case (r_tx_ph)
          2'd0: begin
            // Issue only when busy was low in the cycle before the strobe.
            if (!TX_BUSY) begin
              w_tx_vld_nxt  = 1'b1;
              w_tx_data_nxt = w_tx_byte;
              w_tx_ph_nxt   = 2'd1;
            end else begin
              w_tx_ph_nxt = 2'd0;
            end
          end
          2'd1: begin
            if (!TX_BUSY) begin
              if (r_state == TX_LO) begin
                w_tx_ph_nxt = 2'd2;
              end else begin
                w_tx_ph_nxt = 2'd0;
                w_state_nxt = IDLE;
              end
            end else begin
              w_tx_ph_nxt = 2'd0;  // not accepted, re-issue
            end
          end
          2'd2: begin
            if (TX_BUSY) begin
              w_tx_ph_nxt = 2'd3;
            end else begin
              w_tx_ph_nxt = 2'd2;
            end
          end
          default: begin
            if (!TX_BUSY) begin
              w_tx_ph_nxt = 2'd0;
              w_state_nxt = TX_HI;
            end else begin
              w_tx_ph_nxt = 2'd3;
            end
          end
        endcase
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Timeout counter restarts on every byte and every state change.
    if (!w_tmo_run || RX_D_VLD || (w_state_nxt != r_state)) begin
      w_tmo_nxt = 8'd0;
    end else begin
      w_tmo_nxt = r_tmo_cnt + 8'd1;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_alu_en   <= 1'b0;
      r_tx_vld   <= 1'b0;
      r_gate     <= 1'b0;
      r_addr_out <= 4'd0;
      r_wr_data  <= 8'h00;
      r_alu_fun  <= 4'd0;
      r_tx_data  <= 8'h00;
      r_wr_addr  <= 4'd0;
      r_rd_byte  <= 8'h00;
      r_alu_res  <= 16'h0000;
      r_tx_ph    <= 2'd0;
      r_tmo_cnt  <= 8'd0;
    end else begin
      r_wr_en    <= w_wr_en_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_alu_en   <= w_alu_en_nxt;
      r_tx_vld   <= w_tx_vld_nxt;
      r_gate     <= w_gate_nxt;
      r_addr_out <= w_addr_out_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_alu_fun  <= w_alu_fun_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_rd_byte  <= w_rd_byte_nxt;
      r_alu_res  <= w_alu_res_nxt;
      r_tx_ph    <= w_tx_ph_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
    end
  end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Directed bench for rx_cmd_ctrl: command sequences with hand-computed
// expectations, a simple transmitter model and strobe counters.
module tb_rx_cmd_ctrl;

  localparam int TMO = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic        RX_ERR;
  logic        RF_WrEn, RF_RdEn;
  logic [3:0]  RF_Address;
  logic [7:0]  RF_WrData;
  logic [7:0]  RF_RdData;
  logic        RF_RdData_Valid;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY;

  // transmitter model and monitors
  logic        model_busy = 1'b0;
  logic        ext_busy;
  int          tx_cnt = 0;
  int          n_tx = 0;
  logic [7:0]  tx_log [0:15];
  int          n_wr = 0, n_rd = 0, n_alu = 0, viol = 0;
  logic        prev_busy = 1'b0;

  int total = 0;
  int bad = 0;

  assign TX_BUSY = model_busy | ext_busy;

  rx_cmd_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .TX_BUSY(TX_BUSY)
  );

  always #5 CLK = ~CLK;

  // Transmitter: accepts on TX_D_VLD & !TX_BUSY, then stays busy 4 cycles.
  always @(posedge CLK) begin
    if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) model_busy <= 1'b0;
    end else if (TX_D_VLD === 1'b1 && TX_BUSY === 1'b0) begin
      if (n_tx < 16) tx_log[n_tx[3:0]] <= TX_P_DATA;
      n_tx       <= n_tx + 1;
      model_busy <= 1'b1;
      tx_cnt     <= 4;
    end
  end

  // Strobe counters and TX issue-rule monitor.
  always @(posedge CLK) begin
    if (RF_WrEn === 1'b1) n_wr <= n_wr + 1;
    if (RF_RdEn === 1'b1) n_rd <= n_rd + 1;
    if (ALU_EN === 1'b1) n_alu <= n_alu + 1;
    if (TX_D_VLD === 1'b1 && prev_busy === 1'b1) viol <= viol + 1;
    prev_busy <= TX_BUSY;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  initial begin
    RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; RX_ERR = 1'b0;
    RF_RdData = 8'h00; RF_RdData_Valid = 1'b0;
    ALU_OUT = 16'h0000; ALU_OUT_VLD = 1'b0; ext_busy = 1'b0;
    #1 RST = 1'b0;
    repeat (2) cyc();

    // reset values
    chk("rst_wren",  32'(RF_WrEn), 32'd0);
    chk("rst_rden",  32'(RF_RdEn), 32'd0);
    chk("rst_aluen", 32'(ALU_EN), 32'd0);
    chk("rst_txvld", 32'(TX_D_VLD), 32'd0);
    chk("rst_gate",  32'(CLK_GATE_EN), 32'd0);
    chk("rst_addr",  32'(RF_Address), 32'd0);
    chk("rst_wdata", 32'(RF_WrData), 32'd0);
    chk("rst_fun",   32'(ALU_FUN), 32'd0);
    chk("rst_txd",   32'(TX_P_DATA), 32'd0);
    RST = 1'b1;
    cyc();

    // write AA,05,3C
    send(8'hAA); send(8'h05); send(8'h3C);
    chk("wr_pulse", 32'(RF_WrEn), 32'd1);
    chk("wr_addr",  32'(RF_Address), 32'h5);
    chk("wr_data",  32'(RF_WrData), 32'h3C);
    cyc();
    chk("wr_single", 32'(RF_WrEn), 32'd0);
    chk("wr_cnt",    32'(n_wr), 32'd1);
    chk("wr_no_rd",  32'(n_rd), 32'd0);
    chk("wr_no_alu", 32'(n_alu), 32'd0);
    chk("wr_no_tx",  32'(n_tx), 32'd0);

    // read BB,05 with the transmitter busy when the data returns
    ext_busy = 1'b1;
    RF_RdData = 8'h3C;
    send(8'hBB); send(8'h05);
    chk("rd_pulse", 32'(RF_RdEn), 32'd1);
    chk("rd_addr",  32'(RF_Address), 32'h5);
    RF_RdData_Valid = 1'b1;
    cyc();
    RF_RdData_Valid = 1'b0;
    RF_RdData = 8'hFF;
    cyc(); cyc();
    chk("rd_tx_wait_busy", 32'(TX_D_VLD), 32'd0);
    ext_busy = 1'b0;
    cyc();
    chk("rd_tx_vld",  32'(TX_D_VLD), 32'd1);
    chk("rd_tx_data", 32'(TX_P_DATA), 32'h3C);
    repeat (8) cyc();
    chk("rd_cnt",    32'(n_rd), 32'd1);
    chk("rd_tx_cnt", 32'(n_tx), 32'd1);
    chk("rd_tx_log", 32'(tx_log[0]), 32'h3C);

    // ALU CC,12,34,01 -> 0x0046
    ALU_OUT = 16'h0046;
    send(8'hCC); send(8'h12);
    chk("opa_wr",   32'(RF_WrEn), 32'd1);
    chk("opa_addr", 32'(RF_Address), 32'h0);
    chk("opa_data", 32'(RF_WrData), 32'h12);
    send(8'h34);
    chk("opb_wr",   32'(RF_WrEn), 32'd1);
    chk("opb_addr", 32'(RF_Address), 32'h1);
    chk("opb_data", 32'(RF_WrData), 32'h34);
    chk("gate_pre", 32'(CLK_GATE_EN), 32'd0);
    send(8'h01);
    chk("alu_en",  32'(ALU_EN), 32'd1);
    chk("alu_fun", 32'(ALU_FUN), 32'h1);
    chk("gate_on", 32'(CLK_GATE_EN), 32'd1);
    cyc();
    chk("alu_en_single", 32'(ALU_EN), 32'd0);
    chk("gate_wait",     32'(CLK_GATE_EN), 32'd1);
    send(8'h55);  // dropped while waiting on the ALU
    cyc();
    ALU_OUT_VLD = 1'b1;
    cyc();
    ALU_OUT_VLD = 1'b0;
    ALU_OUT = 16'hFFFF;
    chk("gate_after_vld", 32'(CLK_GATE_EN), 32'd1);
    cyc();
    chk("gate_off",   32'(CLK_GATE_EN), 32'd0);
    chk("tx_lo_vld",  32'(TX_D_VLD), 32'd1);
    chk("tx_lo_data", 32'(TX_P_DATA), 32'h46);
    repeat (16) cyc();
    chk("alu_tx_cnt", 32'(n_tx), 32'd3);
    chk("tx_lo_log",  32'(tx_log[1]), 32'h46);
    chk("tx_hi_log",  32'(tx_log[2]), 32'h00);
    chk("alu_wr_cnt", 32'(n_wr), 32'd3);
    chk("alu_cnt",    32'(n_alu), 32'd1);
    chk("tx_busy_rule", 32'(viol), 32'd0);

    // timeout: TMO idle cycles after AA,05 aborts; 3C is then unknown
    send(8'hAA); send(8'h05);
    repeat (TMO) cyc();
    send(8'h3C);
    repeat (2) cyc();
    chk("tmo_no_wr", 32'(n_wr), 32'd3);
    // one cycle short of the timeout still completes
    send(8'hAA); send(8'h05);
    repeat (TMO - 1) cyc();
    send(8'h3C);
    chk("tmo_edge_wr",   32'(RF_WrEn), 32'd1);
    chk("tmo_edge_data", 32'(RF_WrData), 32'h3C);
    cyc();
    chk("tmo_edge_cnt", 32'(n_wr), 32'd4);

    // RX_ERR in OP_B aborts; the concurrent byte and later bytes are ignored
    send(8'hCC); send(8'h12);
    chk("err_opa_wr", 32'(RF_WrEn), 32'd1);
    RX_ERR = 1'b1; RX_D_VLD = 1'b1; RX_P_DATA = 8'h34;
    cyc();
    RX_ERR = 1'b0; RX_D_VLD = 1'b0;
    send(8'h34); send(8'h01); send(8'h77);
    repeat (4) cyc();
    chk("err_wr_cnt",  32'(n_wr), 32'd5);
    chk("err_alu_cnt", 32'(n_alu), 32'd1);
    chk("err_rd_cnt",  32'(n_rd), 32'd1);
    chk("err_tx_cnt",  32'(n_tx), 32'd3);

    // reset during ALU_WAIT
    send(8'hCC); send(8'h12); send(8'h34); send(8'h01);
    repeat (3) cyc();
    chk("pre_rst_gate", 32'(CLK_GATE_EN), 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("arst_gate",  32'(CLK_GATE_EN), 32'd0);
    chk("arst_addr",  32'(RF_Address), 32'd0);
    chk("arst_wdata", 32'(RF_WrData), 32'd0);
    chk("arst_fun",   32'(ALU_FUN), 32'd0);
    chk("arst_txd",   32'(TX_P_DATA), 32'd0);
    cyc();
    RST = 1'b1;
    ALU_OUT = 16'h1234;
    ALU_OUT_VLD = 1'b1;
    cyc();
    ALU_OUT_VLD = 1'b0;
    repeat (10) cyc();
    chk("post_rst_no_tx", 32'(n_tx), 32'd3);
    chk("post_rst_wr",    32'(n_wr), 32'd7);
    chk("post_rst_alu",   32'(n_alu), 32'd2);
    chk("post_rst_gate",  32'(CLK_GATE_EN), 32'd0);
    send(8'hAA); send(8'h09); send(8'hA5);
    chk("post_rst_cmd_wr",   32'(RF_WrEn), 32'd1);
    chk("post_rst_cmd_addr", 32'(RF_Address), 32'h9);
    chk("post_rst_cmd_data", 32'(RF_WrData), 32'hA5);
    cyc();
    chk("final_busy_rule", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
